id_ex_stage_reg: RTL and testbench

ID_EX_STAGE_REG -- requirements
Module: id_ex_stage_reg

---
 rtl/id_ex_stage_reg_pkg.sv | 29 ++
 rtl/id_ex_stage_reg_sat_counter.sv | 22 ++
 rtl/id_ex_stage_reg.sv | 129 ++++++++++++
 tb/tb_id_ex_stage_reg.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_reg_pkg.sv
// Shared pipeline definitions: control bus widths and bit positions used by control and ID/EX.
package id_ex_stage_reg_pkg;

  localparam int unsigned NB_CTRL_WB = 2;
  localparam int unsigned NB_CTRL_M  = 9;
  localparam int unsigned NB_CTRL_EX = 6;

  // WB bus: [RegWrite, MemtoReg]
  localparam int unsigned WB_REG_WRITE  = 1;
  localparam int unsigned WB_MEM_TO_REG = 0;

  // MEM bus: [SB, SH, LB, LH, Unsigned, BNEQ, Branch, MemRead, MemWrite]
  localparam int unsigned M_SB        = 8;
  localparam int unsigned M_SH        = 7;
  localparam int unsigned M_LB        = 6;
  localparam int unsigned M_LH        = 5;
  localparam int unsigned M_UNSIGNED  = 4;
  localparam int unsigned M_BNEQ      = 3;
  localparam int unsigned M_BRANCH    = 2;
  localparam int unsigned M_MEM_READ  = 1;
  localparam int unsigned M_MEM_WRITE = 0;

  // EX bus: [ALUSrc, AluOp[3:0], RegDst]
  localparam int unsigned EX_ALU_SRC   = 5;
  localparam int unsigned EX_ALU_OP_HI = 4;
  localparam int unsigned EX_ALU_OP_LO = 1;
  localparam int unsigned EX_REG_DST   = 0;

endpackage

// File: rtl/id_ex_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_COUNT = '1;

  // Count up on inc, stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != MAX_COUNT)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: freeze, flush-to-bubble, and bubble statistics.
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int unsigned NB_DATA    = 32,
  parameter int unsigned NB_REG     = 5,
  parameter int unsigned NB_FUNCT   = 6,
  parameter int unsigned NB_CTRL_EX = id_ex_stage_reg_pkg::NB_CTRL_EX,
  parameter int unsigned NB_CTRL_M  = id_ex_stage_reg_pkg::NB_CTRL_M,
  parameter int unsigned NB_CTRL_WB = id_ex_stage_reg_pkg::NB_CTRL_WB,
  parameter int unsigned NB_CNT     = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_flush,
  input  logic                  i_stall_flag,
  input  logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus,
  input  logic [NB_CTRL_M-1:0]  i_ctrl_mem_bus,
  input  logic [NB_CTRL_EX-1:0] i_ctrl_exc_bus,
  input  logic                  i_jal,
  input  logic                  i_jalr,
  input  logic [NB_DATA-1:0]    i_pc_plus4,
  input  logic [NB_DATA-1:0]    i_read_data1,
  input  logic [NB_DATA-1:0]    i_read_data2,
  input  logic [NB_DATA-1:0]    i_sign_ext,
  input  logic [NB_REG-1:0]     i_rs,
  input  logic [NB_REG-1:0]     i_rt,
  input  logic [NB_REG-1:0]     i_rd,
  input  logic [NB_REG-1:0]     i_shamt,
  input  logic [NB_FUNCT-1:0]   i_funct,
  output logic [NB_CTRL_WB-1:0] o_ctrl_wb_bus,
  output logic [NB_CTRL_M-1:0]  o_ctrl_mem_bus,
  output logic [NB_CTRL_EX-1:0] o_ctrl_exc_bus,
  output logic                  o_jal,
  output logic                  o_jalr,
  output logic [NB_DATA-1:0]    o_pc_plus4,
  output logic [NB_DATA-1:0]    o_read_data1,
  output logic [NB_DATA-1:0]    o_read_data2,
  output logic [NB_DATA-1:0]    o_sign_ext,
  output logic [NB_REG-1:0]     o_rs,
  output logic [NB_REG-1:0]     o_rt,
  output logic [NB_REG-1:0]     o_rd,
  output logic [NB_REG-1:0]     o_shamt,
  output logic [NB_FUNCT-1:0]   o_funct,
  output logic                  o_valid,
  output logic [NB_CNT-1:0]     o_bubble_cnt
);

  logic bubble_inc;

  // A flush and a stall in the same advancing cycle are one bubble.
  assign bubble_inc = i_enable & (i_flush | i_stall_flag);

  // Control buses and slot-valid flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ctrl_wb_bus  <= '0;
      o_ctrl_mem_bus <= '0;
      o_ctrl_exc_bus <= '0;
      o_valid        <= 1'b0;
    end else if (i_enable) begin
      if (i_flush) begin
        o_ctrl_wb_bus  <= '0;
        o_ctrl_mem_bus <= '0;
        o_ctrl_exc_bus <= '0;
        o_valid        <= 1'b0;
      end else begin
        o_ctrl_wb_bus  <= i_ctrl_wb_bus;
        o_ctrl_mem_bus <= i_ctrl_mem_bus;
        o_ctrl_exc_bus <= i_ctrl_exc_bus;
        o_valid        <= ~i_stall_flag;
      end
    end
  end

  // Link-instruction flags.
  always_ff @(posedge i_clk) begin
    if (i_rst || (i_enable && i_flush)) begin
      o_jal  <= 1'b0;
      o_jalr <= 1'b0;
    end else if (i_enable) begin
      o_jal  <= i_jal;
      o_jalr <= i_jalr;
    end
  end

  // Operand and PC values.
  always_ff @(posedge i_clk) begin
    if (i_rst || (i_enable && i_flush)) begin
      o_pc_plus4   <= '0;
      o_read_data1 <= '0;
      o_read_data2 <= '0;
      o_sign_ext   <= '0;
    end else if (i_enable) begin
      o_pc_plus4   <= i_pc_plus4;
      o_read_data1 <= i_read_data1;
      o_read_data2 <= i_read_data2;
      o_sign_ext   <= i_sign_ext;
    end
  end

  // Register indices, shift amount and funct field.
  always_ff @(posedge i_clk) begin
    if (i_rst || (i_enable && i_flush)) begin
      o_rs    <= '0;
      o_rt    <= '0;
      o_rd    <= '0;
      o_shamt <= '0;
      o_funct <= '0;
    end else if (i_enable) begin
      o_rs    <= i_rs;
      o_rt    <= i_rt;
      o_rd    <= i_rd;
      o_shamt <= i_shamt;
      o_funct <= i_funct;
    end
  end

  sat_counter #(
    .WIDTH(NB_CNT)
  ) u_bubble_cnt (
    .clk  (i_clk),
    .rst  (i_rst),
    .inc  (bubble_inc),
    .count(o_bubble_cnt)
  );

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Randomized scoreboard bench for id_ex_stage_reg.
module tb_id_ex_stage_reg;

  localparam int unsigned NB_CNT  = 4;
  localparam int          CNT_MAX = (1 << NB_CNT) - 1;

  typedef struct packed {
    logic [1:0]  wb;
    logic [8:0]  mem;
    logic [5:0]  ex;
    logic        jal;
    logic        jalr;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] se;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
  } fields_t;

  typedef struct packed {
    fields_t     f;
    logic        valid;
    logic [3:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_s, en_s, fl_s, st_s;
  fields_t cur;
  fields_t got;
  logic got_valid;
  logic [NB_CNT-1:0] got_cnt;

  exp_t    sb_q[$];
  int      tests = 0;
  int      fails = 0;

  // Reference model state: what the stage should be holding.
  fields_t m_f;
  bit      m_v;
  int      m_c;

  always #5 clk = ~clk;

  id_ex_stage_reg #(
    .NB_CNT(NB_CNT)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst_s),
    .i_enable      (en_s),
    .i_flush       (fl_s),
    .i_stall_flag  (st_s),
    .i_ctrl_wb_bus (cur.wb),
    .i_ctrl_mem_bus(cur.mem),
    .i_ctrl_exc_bus(cur.ex),
    .i_jal         (cur.jal),
    .i_jalr        (cur.jalr),
    .i_pc_plus4    (cur.pc),
    .i_read_data1  (cur.rd1),
    .i_read_data2  (cur.rd2),
    .i_sign_ext    (cur.se),
    .i_rs          (cur.rs),
    .i_rt          (cur.rt),
    .i_rd          (cur.rd),
    .i_shamt       (cur.shamt),
    .i_funct       (cur.funct),
    .o_ctrl_wb_bus (got.wb),
    .o_ctrl_mem_bus(got.mem),
    .o_ctrl_exc_bus(got.ex),
    .o_jal         (got.jal),
    .o_jalr        (got.jalr),
    .o_pc_plus4    (got.pc),
    .o_read_data1  (got.rd1),
    .o_read_data2  (got.rd2),
    .o_sign_ext    (got.se),
    .o_rs          (got.rs),
    .o_rt          (got.rt),
    .o_rd          (got.rd),
    .o_shamt       (got.shamt),
    .o_funct       (got.funct),
    .o_valid       (got_valid),
    .o_bubble_cnt  (got_cnt)
  );

  function automatic fields_t rand_fields();
    fields_t r;
    r.wb    = 2'($urandom);
    r.mem   = 9'($urandom);
    r.ex    = 6'($urandom);
    r.jal   = 1'($urandom);
    r.jalr  = 1'($urandom);
    r.pc    = $urandom;
    r.rd1   = $urandom;
    r.rd2   = $urandom;
    r.se    = $urandom;
    r.rs    = 5'($urandom);
    r.rt    = 5'($urandom);
    r.rd    = 5'($urandom);
    r.shamt = 5'($urandom);
    r.funct = 6'($urandom);
    return r;
  endfunction

  // Drive one cycle of stimulus and queue the state expected after the next edge.
  task automatic step(input fields_t f, input bit rst, input bit en, input bit fl, input bit st);
    exp_t e;
    @(negedge clk);
    cur   = f;
    rst_s = rst;
    en_s  = en;
    fl_s  = fl;
    st_s  = st;
    if (rst) begin
      m_f = '0;
      m_v = 1'b0;
      m_c = 0;
    end else if (en) begin
      if (fl || st) m_c = (m_c < CNT_MAX) ? m_c + 1 : CNT_MAX;
      if (fl) begin
        m_f = '0;
        m_v = 1'b0;
      end else begin
        m_f = f;
        m_v = !st;
      end
    end
    e.f     = m_f;
    e.valid = m_v;
    e.cnt   = 4'(m_c);
    sb_q.push_back(e);
  endtask

  // Monitor: after each edge, compare the DUT against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        tests++;
        if (got !== e.f) begin
          fails++;
          $display("FAIL fields: got %h required %h", got, e.f);
        end
        tests++;
        if (got_valid !== e.valid) begin
          fails++;
          $display("FAIL valid: got %0b required %0b", got_valid, e.valid);
        end
        tests++;
        if (got_cnt !== e.cnt) begin
          fails++;
          $display("FAIL bubble_cnt: got %0d required %0d", got_cnt, e.cnt);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fields_t a, b, ones, dir;
    int wait_cnt;
    cur = '0; rst_s = 1'b1; en_s = 1'b0; fl_s = 1'b0; st_s = 1'b0;
    m_f = '0; m_v = 1'b0; m_c = 0;

    // Reset with all-ones inputs while advancing.
    ones = '1;
    step(ones, 1, 1, 1, 1);
    step(ones, 1, 1, 1, 1);

    // Directed capture.
    dir      = '0;
    dir.wb   = 2'b11;
    dir.mem  = 9'b001000010;
    dir.ex   = 6'b100000;
    dir.rd1  = 32'h0000_1234;
    step(dir, 0, 1, 0, 0);

    // Freeze: hold A while inputs change to B with flush asserted.
    a = rand_fields();
    b = rand_fields();
    step(a, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(b, 0, 0, 1, 1);

    // Flush and stall together count once; then stall only.
    step(rand_fields(), 0, 1, 1, 1);
    step(rand_fields(), 0, 1, 0, 1);

    // Saturation.
    for (int i = 0; i < 20; i++) step(rand_fields(), 0, 1, 0, 1);

    // Reset mid-operation with counter at 5 and a valid slot.
    step(rand_fields(), 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(rand_fields(), 0, 1, 0, 1);
    step(rand_fields(), 0, 1, 0, 0);
    step(rand_fields(), 1, 0, 1, 0);
    step(rand_fields(), 0, 1, 0, 0);
    step(rand_fields(), 0, 1, 0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(rand_fields(),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 4) == 0));
    end

    // Let the monitor drain the scoreboard, bounded.
    @(negedge clk);
    rst_s = 1'b0; en_s = 1'b0; fl_s = 1'b0; st_s = 1'b0;
    wait_cnt = 0;
    while (sb_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      #2;
      wait_cnt++;
    end
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
